gdt_arbiter: RTL and testbench
==============================

GDT_ARBITER -- requirements
Module: gdt_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the max consecutive hypervisor grants while a guest request waits.
REQ-002 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port hv_req  input  1  hypervisor request; level, held with fields stable until hv_gnt.
REQ-005 The block SHALL have port hv_we  input  1  hypervisor access type; 1 = write, 0 = read.
REQ-006 The block SHALL have ports hv_line, hv_col  input  3 each  hypervisor guest line and GDT column.
REQ-007 The block SHALL have port hv_wdata  input  32  hypervisor write data.
REQ-008 The block SHALL have ports hv_gnt, hv_err, hv_rvalid  output  1 each  grant pulse, write-reject pulse, read-data-valid pulse.
REQ-009 The block SHALL have port hv_rdata  output  32  hypervisor read data, valid while hv_rvalid.
REQ-010 The block SHALL have ports gst_req  input  1, gst_line and gst_col  input  3 each  guest read-only request, line and column.
REQ-011 The block SHALL have ports gst_gnt, gst_rvalid  output  1 each, and gst_rdata  output  32  guest grant, valid pulse, read data.
REQ-012 The block SHALL have ports gdt_enable, gdt_rd0_wr1  output  1 each, gdt_line and gdt_column  output  3 each, gdt_wdata  output  32, and gdt_rdata  input  32  GDT memory port.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; all outputs SHALL be registered.
REQ-014 In IDLE with any request high at a clock edge, the FSM SHALL arbitrate, latch the winner's fields, and enter ISSUE.
REQ-015 Arbitration: the hypervisor SHALL win over the guest, except when gst_req is high and the streak counter equals STARVE_LIMIT, in which case the guest SHALL win.
REQ-016 Streak counter (width clog2(STARVE_LIMIT+1)):
- SHALL increment on each hypervisor grant made while gst_req is high.
- SHALL clear on a guest grant.
- SHALL clear on a hypervisor grant made while gst_req is low.
- SHALL saturate at STARVE_LIMIT.
REQ-017 In ISSUE, exactly one of hv_gnt or gst_gnt SHALL be 1 for that single cycle, and gdt_enable SHALL be 1 with gdt_line, gdt_column, gdt_rd0_wr1 and gdt_wdata driven from the latched fields.
REQ-018 A hypervisor write with hv_col = 0 (null descriptor) SHALL still be granted, but gdt_enable SHALL stay 0 and hv_err SHALL pulse in the same cycle as hv_gnt.
REQ-019 After ISSUE, a write SHALL return to IDLE; a read SHALL enter CAPTURE.
REQ-020 In CAPTURE, gdt_enable SHALL be 0, and gdt_rdata SHALL be registered at the closing edge (memory read latency: one cycle after enable).
REQ-021 In RESP, the requester's rvalid SHALL be 1 for one cycle with the captured data on its rdata; the FSM SHALL then return to IDLE.
REQ-022 Latency, req first sampled high at edge n in IDLE:
- gnt high in cycle n+1.
- Read rvalid high in cycle n+3.
- Next arbitration at edge n+2 for writes, n+4 for reads.
REQ-023 A request still high in IDLE after its grant SHALL be treated as a new request; requesters SHALL drop req in the cycle after gnt.
REQ-024 Reads of column 0 SHALL proceed normally; guest writes do not exist (gdt_rd0_wr1 = 0 for every guest access).
REQ-025 hv_rdata and gst_rdata SHALL hold their last value outside rvalid cycles.

Reset
REQ-026 reset_n low SHALL immediately force: FSM to IDLE, streak counter to 0, all 1-bit outputs to 0, and all multi-bit outputs to 0.
REQ-027 Reset asserted mid-transaction SHALL drop that transaction without any rvalid; after release, the block SHALL arbitrate afresh from IDLE.

Verification
REQ-028 Hypervisor write line 0, col 1, data F0FF_FFFF -> in the grant cycle: hv_gnt=1, gdt_enable=1, gdt_rd0_wr1=1, gdt_wdata=F0FF_FFFF; hv_err=0.
REQ-029 Hypervisor read of the same entry, memory returns F0FF_FFFF -> hv_rvalid=1 with hv_rdata=F0FF_FFFF exactly 3 cycles after the request edge.
REQ-030 hv_req and gst_req high in the same cycle, counter 0 -> hypervisor granted first, guest granted on the next arbitration if hv_req has dropped.
REQ-031 hv_req held continuously with gst_req high, STARVE_LIMIT=4 -> 4 hypervisor grants, then 1 guest grant, then the counter is 0.
REQ-032 Hypervisor write to col 0 -> hv_gnt=1, hv_err=1 and gdt_enable=0 in the same cycle.
REQ-033 reset_n pulsed low during CAPTURE -> outputs 0 asynchronously and no rvalid; a following guest read completes normally.

Source files
------------

// File: rtl/gdt_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gdt_arbiter_if                                                |
// | Brief    : Hypervisor / guest request ports and GDT memory port bundle.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface gdt_arbiter_if;
    logic        hv_req;
    logic        hv_we;
    logic [2:0]  hv_line;
    logic [2:0]  hv_col;
    logic [31:0] hv_wdata;
    logic        hv_gnt;
    logic        hv_err;
    logic        hv_rvalid;
    logic [31:0] hv_rdata;

    logic        gst_req;
    logic [2:0]  gst_line;
    logic [2:0]  gst_col;
    logic        gst_gnt;
    logic        gst_rvalid;
    logic [31:0] gst_rdata;

    logic        gdt_enable;
    logic        gdt_rd0_wr1;
    logic [2:0]  gdt_line;
    logic [2:0]  gdt_column;
    logic [31:0] gdt_wdata;
    logic [31:0] gdt_rdata;

    // Arbiter side.
    modport slave (
        input  hv_req, hv_we, hv_line, hv_col, hv_wdata,
        output hv_gnt, hv_err, hv_rvalid, hv_rdata,
        input  gst_req, gst_line, gst_col,
        output gst_gnt, gst_rvalid, gst_rdata,
        output gdt_enable, gdt_rd0_wr1, gdt_line, gdt_column, gdt_wdata,
        input  gdt_rdata
    );

    // Requester / memory side.
    modport master (
        output hv_req, hv_we, hv_line, hv_col, hv_wdata,
        input  hv_gnt, hv_err, hv_rvalid, hv_rdata,
        output gst_req, gst_line, gst_col,
        input  gst_gnt, gst_rvalid, gst_rdata,
        input  gdt_enable, gdt_rd0_wr1, gdt_line, gdt_column, gdt_wdata,
        output gdt_rdata
    );
endinterface

`default_nettype wire

// File: rtl/gdt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gdt_arbiter                                                   |
// | Brief    : Two-requester GDT access arbiter, hypervisor priority with a   |
// |            guest anti-starvation streak limit. All outputs registered.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module gdt_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire          clock,
    input  wire          reset_n,
    gdt_arbiter_if.slave bus
);

    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_limit = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] streak_q, streak_d;
    logic          sel_gst_q, sel_gst_d;
    logic          we_q, we_d;

    logic          hv_gnt_q, hv_gnt_d;
    logic          hv_err_q, hv_err_d;
    logic          hv_rvalid_q, hv_rvalid_d;
    logic [31:0]   hv_rdata_q, hv_rdata_d;
    logic          gst_gnt_q, gst_gnt_d;
    logic          gst_rvalid_q, gst_rvalid_d;
    logic [31:0]   gst_rdata_q, gst_rdata_d;
    logic          gdt_enable_q, gdt_enable_d;
    logic          gdt_we_q, gdt_we_d;
    logic [2:0]    gdt_line_q, gdt_line_d;
    logic [2:0]    gdt_col_q, gdt_col_d;
    logic [31:0]   gdt_wdata_q, gdt_wdata_d;

    logic          w_any_req;
    logic          w_gst_win;
    logic          w_null_wr;

    // Guest only overtakes a waiting hypervisor once the streak has saturated.
    assign w_any_req = bus.hv_req | bus.gst_req;
    assign w_gst_win = bus.gst_req & (~bus.hv_req | (streak_q == c_limit));
    assign w_null_wr = ~w_gst_win & bus.hv_we & (bus.hv_col == 3'd0);

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        sel_gst_d    = sel_gst_q;
        we_d         = we_q;
        hv_gnt_d     = 1'b0;
        hv_err_d     = 1'b0;
        hv_rvalid_d  = 1'b0;
        hv_rdata_d   = hv_rdata_q;
        gst_gnt_d    = 1'b0;
        gst_rvalid_d = 1'b0;
        gst_rdata_d  = gst_rdata_q;
        gdt_enable_d = 1'b0;
        gdt_we_d     = 1'b0;
        gdt_line_d   = gdt_line_q;
        gdt_col_d    = gdt_col_q;
        gdt_wdata_d  = gdt_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    state_d   = ISSUE;
                    sel_gst_d = w_gst_win;
                    hv_gnt_d  = ~w_gst_win;
                    gst_gnt_d = w_gst_win;
                    if (w_gst_win) begin
                        we_d         = 1'b0;
                        gdt_enable_d = 1'b1;
                        gdt_we_d     = 1'b0;
                        gdt_line_d   = bus.gst_line;
                        gdt_col_d    = bus.gst_col;
                        gdt_wdata_d  = 32'd0;
                        streak_d     = '0;
                    end else begin
                        we_d         = bus.hv_we;
                        hv_err_d     = w_null_wr;
                        gdt_enable_d = ~w_null_wr;
                        gdt_we_d     = bus.hv_we;
                        gdt_line_d   = bus.hv_line;
                        gdt_col_d    = bus.hv_col;
                        gdt_wdata_d  = bus.hv_wdata;
                        if (!bus.gst_req) begin
                            streak_d = '0;
                        end else if (streak_q != c_limit) begin
                            streak_d = streak_q + CW'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                // Memory data is valid one cycle after the enable cycle.
                state_d = RESP;
                if (sel_gst_q) begin
                    gst_rvalid_d = 1'b1;
                    gst_rdata_d  = bus.gdt_rdata;
                end else begin
                    hv_rvalid_d = 1'b1;
                    hv_rdata_d  = bus.gdt_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            sel_gst_q    <= 1'b0;
            we_q         <= 1'b0;
            hv_gnt_q     <= 1'b0;
            hv_err_q     <= 1'b0;
            hv_rvalid_q  <= 1'b0;
            hv_rdata_q   <= 32'd0;
            gst_gnt_q    <= 1'b0;
            gst_rvalid_q <= 1'b0;
            gst_rdata_q  <= 32'd0;
            gdt_enable_q <= 1'b0;
            gdt_we_q     <= 1'b0;
            gdt_line_q   <= 3'd0;
            gdt_col_q    <= 3'd0;
            gdt_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            sel_gst_q    <= sel_gst_d;
            we_q         <= we_d;
            hv_gnt_q     <= hv_gnt_d;
            hv_err_q     <= hv_err_d;
            hv_rvalid_q  <= hv_rvalid_d;
            hv_rdata_q   <= hv_rdata_d;
            gst_gnt_q    <= gst_gnt_d;
            gst_rvalid_q <= gst_rvalid_d;
            gst_rdata_q  <= gst_rdata_d;
            gdt_enable_q <= gdt_enable_d;
            gdt_we_q     <= gdt_we_d;
            gdt_line_q   <= gdt_line_d;
            gdt_col_q    <= gdt_col_d;
            gdt_wdata_q  <= gdt_wdata_d;
        end
    end

    assign bus.hv_gnt      = hv_gnt_q;
    assign bus.hv_err      = hv_err_q;
    assign bus.hv_rvalid   = hv_rvalid_q;
    assign bus.hv_rdata    = hv_rdata_q;
    assign bus.gst_gnt     = gst_gnt_q;
    assign bus.gst_rvalid  = gst_rvalid_q;
    assign bus.gst_rdata   = gst_rdata_q;
    assign bus.gdt_enable  = gdt_enable_q;
    assign bus.gdt_rd0_wr1 = gdt_we_q;
    assign bus.gdt_line    = gdt_line_q;
    assign bus.gdt_column  = gdt_col_q;
    assign bus.gdt_wdata   = gdt_wdata_q;

    a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        !(hv_gnt_q && gst_gnt_q));
    a_rvalid_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        !(hv_rvalid_q && gst_rvalid_q));
    a_streak_bound: assert property (@(posedge clock) disable iff (!reset_n)
        streak_q <= c_limit);

endmodule

`default_nettype wire

// File: tb/tb_gdt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gdt_arbiter                                                |
// | Brief    : Vector table plus read-data scoreboard for gdt_arbiter.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_gdt_arbiter;

    localparam int SL = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    gdt_arbiter_if bus();

    gdt_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit          gst;
        bit          we;
        logic [2:0]  line;
        logic [2:0]  col;
        logic [31:0] wdata;
        bit          exp_err;
        bit          exp_en;
    } vec_t;

    typedef struct {
        bit          gst;
        logic [31:0] data;
        int          due;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    bit          mem_ready = 1'b0;

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A00_0000 + i * 32'h0001_0203;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // GDT memory: one-cycle read latency after the enable cycle.
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            bus.gdt_rdata <= 32'd0;
            mem_ready     <= 1'b1;
        end else if (bus.gdt_enable) begin
            if (bus.gdt_rd0_wr1) mem[{bus.gdt_line, bus.gdt_column}] <= bus.gdt_wdata;
            else                 bus.gdt_rdata <= mem[{bus.gdt_line, bus.gdt_column}];
        end
    end

    always @(negedge clock) begin : mon
        exp_t e;
        if (bus.hv_rvalid || bus.gst_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {bus.hv_rvalid, bus.gst_rvalid}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("rvalid_who", {bus.hv_rvalid, bus.gst_rvalid}, e.gst ? 2'b01 : 2'b10);
                check("rdata", e.gst ? bus.gst_rdata : bus.hv_rdata, e.data);
                check("rvalid_cycle", cyc, e.due);
            end
        end
    end

    function automatic logic [127:0] all_outs();
        return {bus.hv_gnt, bus.hv_err, bus.hv_rvalid, bus.gst_gnt, bus.gst_rvalid,
                bus.gdt_enable, bus.gdt_rd0_wr1, bus.gdt_line, bus.gdt_column,
                bus.hv_rdata, bus.gst_rdata, bus.gdt_wdata};
    endfunction

    task automatic txn(input vec_t v);
        int         n;
        logic [5:0] idx;
        idx = {v.line, v.col};
        @(negedge clock);
        if (v.gst) begin
            bus.gst_req  = 1'b1;
            bus.gst_line = v.line;
            bus.gst_col  = v.col;
        end else begin
            bus.hv_req   = 1'b1;
            bus.hv_we    = v.we;
            bus.hv_line  = v.line;
            bus.hv_col   = v.col;
            bus.hv_wdata = v.wdata;
        end
        @(posedge clock); #1;
        n = cyc;
        check("gnt_cycle", {bus.hv_gnt, bus.gst_gnt, bus.hv_err, bus.gdt_enable},
              {!v.gst, v.gst, v.exp_err, v.exp_en});
        if (v.exp_en) check("gdt_cmd", {bus.gdt_rd0_wr1, bus.gdt_line, bus.gdt_column},
                            {v.we, v.line, v.col});
        if (v.exp_en && v.we) check("gdt_wdata", bus.gdt_wdata, v.wdata);
        bus.hv_req  = 1'b0;
        bus.gst_req = 1'b0;
        if (v.we) begin
            if (v.exp_en) ref_mem[idx] = v.wdata;
            @(posedge clock);
        end else begin
            sb.push_back('{v.gst, ref_mem[idx], n + 2});
            repeat (3) @(posedge clock);
            #1;
            check("rdata_hold", v.gst ? bus.gst_rdata : bus.hv_rdata, ref_mem[idx]);
        end
    endtask

    vec_t vecs [9];

    initial begin : main
        int  got;
        bit  exp_g;
        int  hv_before;

        vecs[0] = '{0, 1, 3'd0, 3'd1, 32'hF0FF_FFFF, 0, 1};
        vecs[1] = '{0, 0, 3'd0, 3'd1, 32'h0,         0, 1};
        vecs[2] = '{0, 1, 3'd2, 3'd0, 32'h1234_5678, 1, 0};
        vecs[3] = '{0, 0, 3'd2, 3'd0, 32'h0,         0, 1};
        vecs[4] = '{1, 0, 3'd0, 3'd1, 32'h0,         0, 1};
        vecs[5] = '{0, 1, 3'd7, 3'd7, 32'hDEAD_BEEF, 0, 1};
        vecs[6] = '{1, 0, 3'd7, 3'd7, 32'h0,         0, 1};
        vecs[7] = '{0, 0, 3'd5, 3'd3, 32'h0,         0, 1};
        vecs[8] = '{1, 0, 3'd3, 3'd0, 32'h0,         0, 1};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        bus.hv_req = 1'b0; bus.hv_we = 1'b0; bus.hv_line = 3'd0; bus.hv_col = 3'd0;
        bus.hv_wdata = 32'd0;
        bus.gst_req = 1'b0; bus.gst_line = 3'd0; bus.gst_col = 3'd0;

        // Asynchronous reset with no clock edge in between.
        #1 reset_n = 1'b0;
        #2 check("reset_outs", all_outs(), 128'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        foreach (vecs[i]) txn(vecs[i]);

        // Both request together: hypervisor first, guest on the next arbitration.
        @(negedge clock);
        bus.hv_req = 1'b1; bus.hv_we = 1'b1; bus.hv_line = 3'd1; bus.hv_col = 3'd2;
        bus.hv_wdata = 32'h1111_2222;
        bus.gst_req = 1'b1; bus.gst_line = 3'd4; bus.gst_col = 3'd4;
        @(posedge clock); #1;
        check("both_first", {bus.hv_gnt, bus.gst_gnt}, 2'b10);
        bus.hv_req = 1'b0;
        ref_mem[10] = 32'h1111_2222;
        @(posedge clock);
        @(posedge clock); #1;
        check("both_second", {bus.hv_gnt, bus.gst_gnt}, 2'b01);
        sb.push_back('{1'b1, ref_mem[36], cyc + 2});
        bus.gst_req = 1'b0;
        repeat (4) @(posedge clock);

        // Both held continuously: SL hypervisor grants, then one guest grant, repeating.
        @(negedge clock);
        bus.hv_req = 1'b1; bus.hv_we = 1'b1; bus.hv_line = 3'd6; bus.hv_col = 3'd1;
        bus.hv_wdata = 32'hC0DE_0001;
        bus.gst_req = 1'b1; bus.gst_line = 3'd0; bus.gst_col = 3'd1;
        ref_mem[49] = 32'hC0DE_0001;
        hv_before = 0;
        for (int k = 0; k < 2 * (SL + 1); k++) begin
            got = 0;
            for (int t = 0; t < 12 && got == 0; t++) begin
                @(posedge clock); #1;
                if (bus.hv_gnt || bus.gst_gnt) got = 1;
            end
            if (got == 0) begin
                check("starve_wait", got, 1);
            end else begin
                exp_g = (k % (SL + 1)) == SL;
                check("starve_order", {bus.hv_gnt, bus.gst_gnt}, exp_g ? 2'b01 : 2'b10);
                if (bus.gst_gnt) sb.push_back('{1'b1, ref_mem[1], cyc + 2});
                if (bus.hv_gnt) hv_before++;
            end
        end
        bus.hv_req = 1'b0;
        bus.gst_req = 1'b0;
        check("starve_hv_count", hv_before, 2 * SL);
        repeat (6) @(posedge clock);

        // Reset during CAPTURE: outputs clear at once, no rvalid afterwards.
        @(negedge clock);
        bus.hv_req = 1'b1; bus.hv_we = 1'b0; bus.hv_line = 3'd5; bus.hv_col = 3'd3;
        @(posedge clock); #1;
        check("mid_gnt", {bus.hv_gnt, bus.gdt_enable}, 2'b11);
        bus.hv_req = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1 check("mid_reset_outs", all_outs(), 128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        txn('{1, 0, 3'd5, 3'd3, 32'h0, 0, 1});

        repeat (3) @(posedge clock);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
